// File: rtl/riscv_sim_ctrl.sv
// riscv_sim_ctrl: passive end-of-test monitor (PC-spin halt, watchdog, result register verdict).
// Define RISCV_SIM_CTRL_FINISH_EN to add a simulation-only report-and-$finish block.
module riscv_sim_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned HALT_CYCLES    = 8,
    parameter int unsigned RESULT_REG     = 10,
    parameter logic [31:0] PASS_VALUE     = 32'h0000_0001,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 I_MEM_CSN,
    input  logic [31:0]          I_MEM_ADDR,
    input  logic                 RF_WE,
    input  logic [4:0]           RF_WA,
    input  logic [31:0]          RF_WD,
    output logic                 DONE,
    output logic                 PASS,
    output logic                 FAIL,
    output logic                 TIMEOUT,
    output logic [31:0]          RESULT,
    output logic [CNT_WIDTH-1:0] CYCLE_CNT,
    output logic [CNT_WIDTH-1:0] FETCH_CNT
);
    localparam int SW = $clog2(HALT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [31:0]   last_addr;
    logic [SW-1:0] stall;
    logic          valid;
    logic          fetch, rep, halt, tmo, wr, pass_now;

    always_comb begin
        fetch     = !I_MEM_CSN;
        rep       = fetch && I_MEM_ADDR == last_addr;
        wr        = RF_WE && RF_WA == 5'(RESULT_REG) && RESULT_REG != 0 && state != FIN;
        // the verdict sees a qualifying write landing on the halting edge
        pass_now  = (valid || wr) && (wr ? RF_WD : RESULT) == PASS_VALUE;
        halt      = state == RUN && rep && stall == SW'(HALT_CYCLES - 1);
        tmo       = state == RUN && CYCLE_CNT == CNT_WIDTH'(TIMEOUT_CYCLES);
        state_nxt = (state == IDLE && fetch) ? RUN : (halt || tmo) ? FIN : state;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            last_addr <= '0;
            stall     <= '0;
            valid     <= 1'b0;
            RESULT    <= '0;
            CYCLE_CNT <= '0;
            FETCH_CNT <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr) begin
                RESULT <= RF_WD;
                valid  <= 1'b1;
            end
            if (state == IDLE && fetch) begin
                last_addr <= I_MEM_ADDR;
                stall     <= '0;
                CYCLE_CNT <= CNT_WIDTH'(1);
                FETCH_CNT <= CNT_WIDTH'(1);
            end
            if (state == RUN) begin
                if (fetch) begin
                    FETCH_CNT <= FETCH_CNT + CNT_WIDTH'(FETCH_CNT != '1);
                    stall     <= rep ? stall + 1'b1 : '0;
                    last_addr <= I_MEM_ADDR;
                end
                if (!tmo)
                    CYCLE_CNT <= CYCLE_CNT + CNT_WIDTH'(CYCLE_CNT != '1);
                if (halt) begin
                    DONE <= 1'b1;
                    PASS <= pass_now;
                    FAIL <= !pass_now;
                end else if (tmo) begin
                    DONE    <= 1'b1;
                    TIMEOUT <= 1'b1;
                end
            end
        end
    end

`ifdef RISCV_SIM_CTRL_FINISH_EN
    logic done_d;
    always_ff @(posedge CLK) begin
        done_d <= RSTn && DONE;
        if (RSTn && DONE && !done_d) begin
            $display("riscv_sim_ctrl: %s RESULT=%h CYCLE_CNT=%0d FETCH_CNT=%0d",
                     PASS ? "PASS" : TIMEOUT ? "TIMEOUT" : "FAIL", RESULT, CYCLE_CNT, FETCH_CNT);
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// tb_riscv_sim_ctrl: directed scenarios plus randomized runs against a fetch-history reference model.
module tb_riscv_sim_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, csn = 1'b1, we = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [4:0]  wa = '0;
    logic        done, pass, fail, tmo;
    logic [31:0] result, cyc, fcnt;

    always #5 clk = ~clk;

    riscv_sim_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .CLK(clk), .RSTn(rstn), .I_MEM_CSN(csn), .I_MEM_ADDR(addr),
        .RF_WE(we), .RF_WA(wa), .RF_WD(wd),
        .DONE(done), .PASS(pass), .FAIL(fail), .TIMEOUT(tmo),
        .RESULT(result), .CYCLE_CNT(cyc), .FETCH_CNT(fcnt)
    );

    int n_cmp = 0, n_bad = 0;

    // reference model: full list of sampled fetch addresses, halt = last 9 identical
    bit          m_started, m_done, m_pass, m_fail, m_tmo, m_valid;
    logic [31:0] m_result;
    int          m_cyc, m_fetch;
    logic [31:0] fq[$];

    task automatic model_reset();
        m_started = 0; m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_valid = 0;
        m_result = '0; m_cyc = 0; m_fetch = 0; fq.delete();
    endtask

    task automatic step(input bit c, input logic [31:0] a, input bit w,
                        input logic [4:0] ra, input logic [31:0] d);
        bit h, to;
        rstn = 1; csn = c; addr = a; we = w; wa = ra; wd = d;
        if (w && ra == 5'd10 && !m_done) begin
            m_result = d;
            m_valid  = 1;
        end
        if (!m_started) begin
            if (!c) begin
                m_started = 1; m_cyc = 1; m_fetch = 1; fq.push_back(a);
            end
        end else if (!m_done) begin
            to = (m_cyc == 50);
            if (!c) begin
                fq.push_back(a);
                m_fetch++;
            end
            h = !c && fq.size() >= 9;
            if (h) for (int i = 1; i < 9; i++) if (fq[fq.size()-1-i] != a) h = 0;
            if (h) begin
                m_done = 1; m_pass = m_valid && m_result == 32'h1; m_fail = !m_pass;
            end else if (to) begin
                m_done = 1; m_tmo = 1;
            end
            if (!to) m_cyc++;
        end
        @(posedge clk); #1;
        csn = 1; we = 0;
    endtask

    task automatic do_reset();
        rstn = 0; csn = 1'($urandom); addr = $urandom; we = 1; wa = 5'd10; wd = 32'h1;
        @(posedge clk); #1;
        rstn = 1; csn = 1; we = 0;
        model_reset();
    endtask

    task automatic pass_seq(input bit w, input logic [31:0] v);
        for (int i = 0; i < 4; i++) step(0, 32'(i*4), 0, 0, 0);
        if (w) step(1, 0, 1, 5'd10, v);
        for (int i = 0; i < 8; i++) step(0, 32'h10, 0, 0, 0);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL pre_halt_done: got %0b want 0", done); end
        step(0, 32'h10, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b0 || result !== '0 || cyc !== '0 || fcnt !== '0) begin
            n_bad++;
            $display("FAIL reset: got flags=%b res=%h cyc=%0d fetch=%0d want all 0", {done, pass, fail, tmo}, result, cyc, fcnt);
        end
    endtask

    task automatic test_pass();
        do_reset();
        pass_seq(1, 32'h1);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1100) begin n_bad++; $display("FAIL pass_flags: got %b want 1100", {done, pass, fail, tmo}); end
        n_cmp++;
        if (fcnt !== 32'd13 || result !== 32'h1) begin n_bad++; $display("FAIL pass_counts: got fetch=%0d res=%h want 13 1", fcnt, result); end
        n_cmp++;
        if (cyc !== 32'(m_cyc)) begin n_bad++; $display("FAIL pass_cycles: got %0d want %0d", cyc, m_cyc); end
    endtask

    task automatic test_fail_value();
        do_reset();
        pass_seq(1, 32'h5);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1010 || result !== 32'h5) begin
            n_bad++; $display("FAIL fail_value: got %b res=%h want 1010 5", {done, pass, fail, tmo}, result);
        end
    endtask

    task automatic test_no_result();
        do_reset();
        pass_seq(0, 0);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1010 || result !== 32'h0 || fcnt !== 32'd13) begin
            n_bad++; $display("FAIL no_result: got %b res=%h fetch=%0d want 1010 0 13", {done, pass, fail, tmo}, result, fcnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 50; i++) step(0, 32'(i*4), 0, 0, 0);
        n_cmp++;
        if (done !== 1'b0 || cyc !== 32'd50) begin n_bad++; $display("FAIL pre_timeout: got done=%0b cyc=%0d want 0 50", done, cyc); end
        step(0, 32'd200, 0, 0, 0);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1001 || cyc !== 32'd50) begin
            n_bad++; $display("FAIL timeout: got %b cyc=%0d want 1001 50", {done, pass, fail, tmo}, cyc);
        end
        step(1, 0, 1, 5'd10, 32'h1);
        for (int i = 0; i < 10; i++) step(0, 32'h80, 0, 0, 0);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1001 || cyc !== 32'd50 || fcnt !== 32'(m_fetch) || result !== 32'h0) begin
            n_bad++; $display("FAIL timeout_sticky: got %b cyc=%0d fetch=%0d res=%h want 1001 50 %0d 0", {done, pass, fail, tmo}, cyc, fcnt, result, m_fetch);
        end
    endtask

    task automatic test_bubbles_x0();
        do_reset();
        step(0, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, 1, 5'd0, 32'h1);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                n_cmp++;
                if (done !== 1'b0) begin n_bad++; $display("FAIL bubble_pre_halt: got %0b want 0", done); end
            end
            step(0, 32'h0, 0, 0, 0);
            for (int b = $urandom_range(0, 2); b > 0; b--) step(1, $urandom, 0, 0, 0);
        end
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1010 || result !== 32'h0 || fcnt !== 32'd10) begin
            n_bad++; $display("FAIL bubble_x0: got %b res=%h fetch=%0d want 1010 0 10", {done, pass, fail, tmo}, result, fcnt);
        end
        n_cmp++;
        if (cyc !== 32'(m_cyc)) begin n_bad++; $display("FAIL bubble_cycles: got %0d want %0d", cyc, m_cyc); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        step(0, 0, 1, 5'd10, 32'h1);
        step(0, 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h10, 0, 0, 0);
        do_reset();
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b0 || result !== '0 || cyc !== '0 || fcnt !== '0) begin
            n_bad++; $display("FAIL midrun_reset: got flags=%b res=%h cyc=%0d fetch=%0d want all 0", {done, pass, fail, tmo}, result, cyc, fcnt);
        end
        pass_seq(1, 32'h1);
        n_cmp++;
        if ({done, pass, fail, tmo} !== 4'b1100 || fcnt !== 32'd13 || cyc !== 32'd14) begin
            n_bad++; $display("FAIL rerun_pass: got %b fetch=%0d cyc=%0d want 1100 13 14", {done, pass, fail, tmo}, fcnt, cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] prev;
        logic [4:0]  ra;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            prev = $urandom;
            for (int k = 0; k < 90; k++) begin
                if ($urandom_range(0, 3) == 0) prev = {$urandom_range(0, 7), 2'b00};
                ra = ($urandom_range(0, 2) == 0) ? 5'd0 : ($urandom_range(0, 1) == 0) ? 5'd10 : 5'($urandom);
                step($urandom_range(0, 4) == 0, prev, $urandom_range(0, 4) == 0, ra,
                     ($urandom_range(0, 1) == 0) ? 32'h1 : $urandom);
                n_cmp++;
                if ({done, pass, fail, tmo} !== {m_done, m_pass, m_fail, m_tmo} || result !== m_result ||
                    cyc !== 32'(m_cyc) || fcnt !== 32'(m_fetch)) begin
                    n_bad++;
                    $display("FAIL random r%0d k%0d: got %b res=%h cyc=%0d fetch=%0d want %b res=%h cyc=%0d fetch=%0d",
                             r, k, {done, pass, fail, tmo}, result, cyc, fcnt,
                             {m_done, m_pass, m_fail, m_tmo}, m_result, m_cyc, m_fetch);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass();
        test_fail_value();
        test_no_result();
        test_timeout();
        test_bubbles_x0();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
